// File: rtl/countdown_timer4_pkg.sv
// Shared constants for the 4-bit countdown timer: state encoding and count width.
package countdown_timer4_pkg;

    localparam int   CNT_W   = 4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/countdown_timer4_register4.sv
// Register4: 4-bit load-enabled register with asynchronous active-low reset.
module Register4
    import countdown_timer4_pkg::*;
(
    input  logic             clock,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_d,
    output logic [CNT_W-1:0] o_q
);

    logic [CNT_W-1:0] r_q;

    // Capture i_d whenever enabled; otherwise hold.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)    r_q <= '0;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/countdown_timer4.sv
// countdown_timer4: loadable down-counter with run/stop, expiry pulse and optional
// auto-reload. Per-edge priority is load > stop > start > tick.
module countdown_timer4
    import countdown_timer4_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] in,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    output logic [CNT_W-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] r_count;
    logic             r_state;
    logic             r_done;

    logic [CNT_W-1:0] w_reload;
    logic [CNT_W-1:0] w_nxt_count;
    logic             w_nxt_state;
    logic             w_nxt_done;

    // Reload value is captured alongside the count on every load.
    Register4 u_reload (
        .clock (clock),
        .rst_n (rst_n),
        .i_en  (load),
        .i_d   (in),
        .o_q   (w_reload)
    );

    // Next-state decode; start while running falls through to the tick branch.
    always_comb begin
        w_nxt_count = r_count;
        w_nxt_state = r_state;
        w_nxt_done  = 1'b0;
        if (load) begin
            w_nxt_count = in;
            w_nxt_state = ST_IDLE;
        end else if (stop) begin
            w_nxt_state = ST_IDLE;
        end else if (start && r_state == ST_IDLE) begin
            // Starting with nothing to count expires immediately.
            if (r_count != '0) w_nxt_state = ST_RUN;
            else               w_nxt_done  = 1'b1;
        end else if (r_state == ST_RUN && tick) begin
            if (r_count > CNT_W'(1)) begin
                w_nxt_count = r_count - CNT_W'(1);
            end else if (r_count == CNT_W'(1)) begin
                w_nxt_done = 1'b1;
                if (AUTO_RELOAD) begin
                    w_nxt_count = w_reload;
                end else begin
                    w_nxt_count = '0;
                    w_nxt_state = ST_IDLE;
                end
            end
        end
    end

    // Count, state and done registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_nxt_count;
            r_state <= w_nxt_state;
            r_done  <= w_nxt_done;
        end
    end

    assign out  = r_count;
    assign zero = (r_count == '0);
    assign busy = (r_state == ST_RUN);
    assign done = r_done;

endmodule

// File: tb/tb_countdown_timer4.sv
// Bench for countdown_timer4: one-shot and auto-reload instances share stimulus;
// each vector names which instance it checks.
module tb_countdown_timer4;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in    = '0;
    logic       load  = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       tick  = 1'b0;

    logic [3:0] out0, out1;
    logic       zero0, zero1, busy0, busy1, done0, done1;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        bit       sel;   // 0: one-shot instance, 1: auto-reload instance
        bit       ld, st, sp, tk;
        bit [3:0] din;
        bit [3:0] eout;
        bit       eb, ed;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    countdown_timer4 #(.AUTO_RELOAD(1'b0)) dut0 (
        .clock(clock), .rst_n(rst_n), .in(in), .load(load), .start(start),
        .stop(stop), .tick(tick), .out(out0), .zero(zero0), .busy(busy0), .done(done0)
    );

    countdown_timer4 #(.AUTO_RELOAD(1'b1)) dut1 (
        .clock(clock), .rst_n(rst_n), .in(in), .load(load), .start(start),
        .stop(stop), .tick(tick), .out(out1), .zero(zero1), .busy(busy1), .done(done1)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(bit sel, bit ld, bit st, bit sp, bit tk, bit [3:0] din,
                                bit [3:0] eout, bit eb, bit ed);
        vec_t v;
        v.sel = sel; v.ld = ld; v.st = st; v.sp = sp; v.tk = tk; v.din = din;
        v.eout = eout; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
    endtask

    task automatic check_all(string tag, int idx, bit sel, bit [3:0] eout, bit ez, bit eb, bit ed);
        chk({tag, ".out"},  idx, sel ? int'(out1)  : int'(out0),  int'(eout));
        chk({tag, ".zero"}, idx, sel ? int'(zero1) : int'(zero0), int'(ez));
        chk({tag, ".busy"}, idx, sel ? int'(busy1) : int'(busy0), int'(eb));
        chk({tag, ".done"}, idx, sel ? int'(done1) : int'(done0), int'(ed));
    endtask

    // Drive one vector at the falling edge, queue its expectation, compare after the rise.
    task automatic apply(vec_t v, int idx);
        vec_t e;
        @(negedge clock);
        load = v.ld; start = v.st; stop = v.sp; tick = v.tk; in = v.din;
        sb.push_back(v);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_all("vec", idx, e.sel, e.eout, e.eout == 4'd0, e.eb, e.ed);
    endtask

    initial begin
        // ---- one-shot: load 5, start (no decrement on start edge), count to 0
        vecs.push_back(mk(0, 1,0,0,0, 4'd5, 4'd5, 0, 0));
        vecs.push_back(mk(0, 0,1,0,1, 4'd0, 4'd5, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd4, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd3, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd2, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd1, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd0, 0, 0));
        // ---- auto-reload: load 3, start, 10 ticks -> 2,1,3,2,1,3,2,1,3,2
        vecs.push_back(mk(1, 1,0,0,0, 4'd3, 4'd3, 0, 0));
        vecs.push_back(mk(1, 0,1,0,1, 4'd0, 4'd3, 1, 0));
        for (int k = 0; k < 10; k++) begin
            bit [3:0] o;
            o = (k % 3 == 0) ? 4'd2 : (k % 3 == 1) ? 4'd1 : 4'd3;
            vecs.push_back(mk(1, 0,0,0,1, 4'd0, o, 1, (k % 3 == 2)));
        end
        // ---- tick gating, stop, hold, resume
        vecs.push_back(mk(0, 1,0,0,0, 4'd4, 4'd4, 0, 0));
        vecs.push_back(mk(0, 0,1,0,0, 4'd0, 4'd4, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd3, 1, 0));
        vecs.push_back(mk(0, 0,0,0,0, 4'd0, 4'd3, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd2, 1, 0));
        vecs.push_back(mk(0, 0,0,1,1, 4'd0, 4'd2, 0, 0));
        for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd2, 0, 0));
        vecs.push_back(mk(0, 0,1,0,1, 4'd0, 4'd2, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd1, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd0, 0, 1));
        // ---- load+start together: load wins
        vecs.push_back(mk(0, 1,1,0,1, 4'd7, 4'd7, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd7, 0, 0));
        // ---- start on zero: single done pulse, stays idle
        vecs.push_back(mk(0, 1,0,0,0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(0, 0,1,0,1, 4'd0, 4'd0, 0, 1));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd0, 0, 0));
        // ---- load during run aborts without done
        vecs.push_back(mk(0, 1,0,0,0, 4'd6, 4'd6, 0, 0));
        vecs.push_back(mk(0, 0,1,0,1, 4'd0, 4'd6, 1, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd5, 1, 0));
        vecs.push_back(mk(0, 1,0,0,1, 4'd9, 4'd9, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd9, 0, 0));
        // ---- stop+start while running: stop wins
        vecs.push_back(mk(0, 1,0,0,0, 4'd3, 4'd3, 0, 0));
        vecs.push_back(mk(0, 0,1,0,0, 4'd0, 4'd3, 1, 0));
        vecs.push_back(mk(0, 0,1,1,1, 4'd0, 4'd3, 0, 0));
        // ---- expiry coinciding with stop: hold at 1, no done (both modes)
        vecs.push_back(mk(0, 1,0,0,0, 4'd2, 4'd2, 0, 0));
        vecs.push_back(mk(0, 0,1,0,1, 4'd0, 4'd2, 1, 0));
        vecs.push_back(mk(1, 0,0,0,1, 4'd0, 4'd1, 1, 0));
        vecs.push_back(mk(1, 0,0,1,1, 4'd0, 4'd1, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 4'd0, 4'd1, 0, 0));
        // ---- auto-reload with reload=1: done stays high continuously
        vecs.push_back(mk(1, 1,0,0,0, 4'd1, 4'd1, 0, 0));
        vecs.push_back(mk(1, 0,1,0,1, 4'd0, 4'd1, 1, 0));
        vecs.push_back(mk(1, 0,0,0,1, 4'd0, 4'd1, 1, 1));
        vecs.push_back(mk(1, 0,0,0,1, 4'd0, 4'd1, 1, 1));
        vecs.push_back(mk(1, 0,0,0,0, 4'd0, 4'd1, 1, 0));

        // Reset state
        #2;
        check_all("reset0", 0, 0, 4'd0, 1, 0, 0);
        check_all("reset1", 0, 1, 4'd0, 1, 0, 0);
        @(negedge clock);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset mid-run: must clear immediately, no clock edge needed
        apply(mk(0, 1,0,0,0, 4'd9, 4'd9, 0, 0), 100);
        apply(mk(0, 0,1,0,1, 4'd0, 4'd9, 1, 0), 101);
        apply(mk(0, 0,0,0,1, 4'd0, 4'd8, 1, 0), 102);
        apply(mk(0, 0,0,0,1, 4'd0, 4'd7, 1, 0), 103);
        apply(mk(0, 0,0,0,1, 4'd0, 4'd6, 1, 0), 104);
        @(negedge clock);
        #1;
        rst_n = 1'b0;
        #1;
        check_all("rst_midrun0", 105, 0, 4'd0, 1, 0, 0);
        check_all("rst_midrun1", 105, 1, 4'd0, 1, 0, 0);
        @(negedge clock);
        rst_n = 1'b1;

        chk("sb_empty", 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/countdown_timer4.md
# countdown_timer4

4-bit programmable down-counter with run/stop control, terminal-count pulse and optional auto-reload. It is the decrementing counterpart of the machine's up-counting sequence/program counters. The control unit uses it for loop counts, wait states and periodic ticks. It loads a 4-bit value, counts down once per qualified tick, and signals expiry to the sequencer.

## Interface
- AUTO_RELOAD, 0: 0 = one-shot (stop at zero); 1 = periodic (reload on expiry, keep running)
- clock  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in  in  4  load value (initial count and reload value)
- load  in  1  capture `in` into count and reload registers
- start  in  1  begin/resume counting
- stop  in  1  halt counting, hold count
- tick  in  1  decrement qualifier (prescaler enable); tie 1 for per-cycle counting
- out  out  4  current count (registered)
- zero  out  1  out == 0 (combinational from count register)
- busy  out  1  high while in RUN (registered)
- done  out  1  one-cycle expiry pulse (registered)

## Operation
- Registers: count[3:0], reload[3:0], state {IDLE, RUN}, done.
- Reset (rst_n=0, any time, including mid-run): count=0, reload=0, state=IDLE, done=0; so out=0, zero=1, busy=0, done=0.
- Per-edge priority: load > stop > start > tick.
- load: count<=in, reload<=in, state<=IDLE. Aborts a run. No done pulse.
- stop: in RUN, state<=IDLE and count holds. In IDLE, no effect.
- start in IDLE with count!=0: state<=RUN. Later start resumes from the held count.
- start in IDLE with count==0: done<=1 for one cycle, state stays IDLE.
- start in RUN: ignored.
- RUN, tick=1, count>1: count<=count-1.
- RUN, tick=1, count==1:
  - AUTO_RELOAD=0: count<=0, state<=IDLE, done<=1.
  - AUTO_RELOAD=1: count<=reload, state stays RUN, done<=1. The value 0 is never shown while running.
- RUN, tick=0: hold.
- done defaults to 0 every edge unless set as above. It never stays high two consecutive cycles, except on back-to-back expiries with reload=1 in auto mode, where done stays high continuously.
- No wrap-around: count never decrements below 0. Underflow is impossible by construction.

## Timing
- Load at edge k: out=in after edge k.
- Start at edge k: busy=1 after edge k. The first decrement occurs at edge k+1 if tick=1. A start and a tick in the same cycle do not decrement.
- One-shot with value N and tick held high: start at edge k; out reaches 0, done=1 and busy=0 after edge k+N. done falls after edge k+N+1.
- Auto-reload with value N and tick held high: done pulses every N cycles. The out sequence is N, N-1, …, 1, N, ….
- Stop at edge k: busy=0 after edge k, and no decrement at edge k.
- Simultaneous load+start: load wins, state=IDLE, start is lost.
- Simultaneous stop+start: stop wins.
- Expiry coinciding with stop: stop wins, count holds at 1, no done.

## Structure
- Shared package: state encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1, and the 4-bit count width constant.
- Reload storage: instance of the team's Register4 (load-enabled, async active-low reset), loaded by `load`.
- Count, state and done live in the top module's single async-reset always block.
- Combinational assigns for zero and busy.

## Test plan
- Reset mid-run: load 9, start, run 3 cycles, assert rst_n=0 -> out=0, zero=1, busy=0, done=0 immediately, without waiting for a clock edge.
- One-shot: load 5, start, tick=1 -> out 5,4,3,2,1,0. done high for exactly one cycle, coincident with out=0. busy falls at the same edge.
- Auto-reload (AUTO_RELOAD=1): load 3, start, tick=1 for 10 cycles -> out 3,2,1,3,2,1,…. done pulses every 3 cycles. busy stays 1.
- Tick gating and stop/resume: load 4, start, tick alternating 1/0 -> one decrement per tick. stop at out=2 -> busy=0, out holds at 2 for 5 cycles. start -> resumes 2,1,0 with done.
- Priority: load 7 + start together -> out=7, busy=0. start on out=0 -> single done pulse, busy stays 0. load during RUN -> run aborted, out=new value, no done.
